instruction_memory_responder: RTL and testbench
===============================================

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 5, meaning clock edges from request capture to data ready; legal range 1-255.
REQ-002 SHALL have parameter BLOCK_INDEX_BITS, default 8, meaning log2 of the number of 128-bit blocks (256 blocks, 4 KiB).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_read  input  1  block read request from the instruction cache, held high until the read completes.
REQ-006 SHALL have port mem_address  input  28  block address, i.e. byte address bits [31:4].
REQ-007 SHALL have port mem_readinst  output  128  returned block; word 0 in [31:0], word 3 in [127:96].
REQ-008 SHALL have port mem_busywait  output  1  high while a request is pending and its data is not yet valid.
REQ-009 SHALL have port prog_en  input  1  preload write strobe.
REQ-010 SHALL have port prog_addr  input  32  preload byte address; bits [1:0] ignored.
REQ-011 SHALL have port prog_data  input  32  preload instruction word.

Function
REQ-012 SHALL implement FSM states IDLE, READ, RESPOND.
REQ-013 In IDLE, mem_busywait SHALL equal mem_read combinationally, so a new request sees busywait high in the same cycle it is raised.
REQ-014 IDLE with mem_read=1 at an edge SHALL latch mem_address, load the counter with READ_LATENCY-1 and enter READ.
REQ-015 In READ, mem_busywait SHALL be 1; the counter SHALL decrement each edge; on the edge where it is 0, mem_readinst SHALL load the addressed block and the state SHALL become RESPOND.
REQ-016 In RESPOND, mem_busywait SHALL be 0; the next edge SHALL return to IDLE unconditionally.
REQ-017 mem_busywait SHALL go low exactly READ_LATENCY edges after the capturing edge.
REQ-018 mem_readinst SHALL hold its value until the next read completes, including through IDLE.
REQ-019 Block index SHALL be the latched mem_address[BLOCK_INDEX_BITS-1:0]; higher bits ignored, giving wrap-around aliasing.
REQ-020 Changes on mem_address after capture SHALL be ignored until the next request.
REQ-021 mem_read falling while in READ SHALL abort: next edge to IDLE, mem_readinst unchanged.
REQ-022 prog_en=1 at an edge SHALL write prog_data to word prog_addr[3:2] of block prog_addr[BLOCK_INDEX_BITS+3:4] in any state.
REQ-023 A preload to the in-flight block before the completing edge SHALL be visible in the returned data; a write on the completing edge itself SHALL return the pre-write data.

Reset
REQ-024 reset low SHALL immediately force state IDLE, counter 0, mem_readinst 0 and mem_busywait 0, regardless of mem_read.
REQ-025 Reset SHALL NOT clear the storage array; preloaded contents survive.
REQ-026 Reset during READ SHALL abort the read; after release, a still-high mem_read SHALL be treated as a new request.

Structure
REQ-027 The shared package/header SHALL hold the state encoding (IDLE=2'b00, READ=2'b01, RESPOND=2'b10), BLOCK_WIDTH=128, BLOCK_ADDR_WIDTH=28 and the default READ_LATENCY.
REQ-028 Storage SHALL be one sub-module, imem_block_array: one 128-bit combinational read port and one 32-bit word-write port.

Verification
REQ-029 Preload blocks 0x00 and 0x01 (words 0x00000013, 0x00100093, 0x00200113, 0x00300193), then mem_read=1 with mem_address=0x0000001 -> busywait high same cycle, low after 5 edges, mem_readinst=0x00300193_00200113_00100093_00000013.
REQ-030 Back-to-back reads of 0x0000000 then 0x0000001, with mem_read dropping for one cycle between -> two 5-edge stalls and correct blocks; mem_readinst holds the first block in between.
REQ-031 Read 0x0000100 with BLOCK_INDEX_BITS=8 -> returns block 0x00 data (aliasing).
REQ-032 mem_read dropped after 2 edges of READ -> IDLE next edge, busywait 0, mem_readinst unchanged; a later full read is correct.
REQ-033 reset low at edge 3 of a read -> busywait and mem_readinst 0 immediately, array intact; re-read after release returns the preloaded block after 5 edges.
REQ-034 prog write to word 2 of the in-flight block at edge 2 of READ -> the returned block contains the new word.

Source files
------------

// File: rtl/instruction_memory_responder_pkg.sv
// Shared definitions for the instruction memory responder.
// Holds the responder FSM encoding, block geometry, the default read latency
// and the preload request bundle used between the top and its storage.
package instruction_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    RESPOND = 2'b10
  } state_e;

  localparam int BLOCK_WIDTH          = 128;
  localparam int BLOCK_ADDR_WIDTH     = 28;
  localparam int DEFAULT_READ_LATENCY = 5;
  localparam int WORD_W               = 32;
  localparam int NUM_LANES            = BLOCK_WIDTH / WORD_W;
  localparam int CNT_W                = 8;

  // One preload write strobe with its byte address and word.
  typedef struct packed {
    logic              en;
    logic [31:0]       addr;
    logic [WORD_W-1:0] data;
  } prog_req_t;

endpackage

// File: rtl/imem_block_array.sv
// Instruction storage: 2**IDX_W blocks of NUM_LANES 32-bit words.
// Ports:
//   clock   - write clock
//   rd_idx  - block index for the combinational 128-bit read port
//   rd_data - addressed block, lane 0 = word 0 = bits [31:0]
//   wr_en   - word write strobe
//   wr_idx  - block index of the word write
//   wr_lane - word within the block
//   wr_data - word to write
// The array has no reset so preloaded contents survive a responder reset.
module imem_block_array
  import instruction_memory_responder_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic                                clock,
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic [NUM_LANES-1:0][WORD_W-1:0]    rd_data,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [1:0]                          wr_lane,
  input  logic [WORD_W-1:0]                   wr_data
);

  // One word-wide memory per lane; a write touches exactly one lane.
  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    localparam logic [1:0] LANE_SEL = 2'(lane);
    logic [WORD_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clock) begin
      if (wr_en && (wr_lane == LANE_SEL)) mem[wr_idx] <= wr_data;
    end

    assign rd_data[lane] = mem[rd_idx];
  end

endmodule

// File: rtl/instruction_memory_responder.sv
// Fixed-latency instruction memory model answering block reads from an
// instruction cache, with a word-wide preload port for loading programs.
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-low
//   mem_read     - block read request, held until the read completes
//   mem_address  - block address (byte address [31:4])
//   mem_readinst - returned 128-bit block, held until the next completion
//   mem_busywait - high while a request is pending without valid data
//   prog_en      - preload write strobe
//   prog_addr    - preload byte address, [1:0] ignored
//   prog_data    - preload instruction word
module instruction_memory_responder
  import instruction_memory_responder_pkg::*;
#(
  parameter int READ_LATENCY     = DEFAULT_READ_LATENCY,
  parameter int BLOCK_INDEX_BITS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mem_read,
  input  logic [BLOCK_ADDR_WIDTH-1:0] mem_address,
  output logic [BLOCK_WIDTH-1:0]      mem_readinst,
  output logic                        mem_busywait,
  input  logic                        prog_en,
  input  logic [31:0]                 prog_addr,
  input  logic [WORD_W-1:0]           prog_data
);

  localparam int IDX_W = BLOCK_INDEX_BITS;

  prog_req_t prog;
  assign prog = '{en: prog_en, addr: prog_addr, data: prog_data};

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [BLOCK_WIDTH-1:0]           readinst_d;
  logic [NUM_LANES-1:0][WORD_W-1:0] rd_data;
  logic                             busy;

  imem_block_array #(.IDX_W(IDX_W)) u_array (
    .clock   (clock),
    .rd_idx  (idx_q),
    .rd_data (rd_data),
    .wr_en   (prog.en),
    .wr_idx  (prog.addr[IDX_W+3:4]),
    .wr_lane (prog.addr[3:2]),
    .wr_data (prog.data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    readinst_d = mem_readinst;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        // A new request sees busywait in the same cycle it is raised.
        busy = mem_read;
        if (mem_read) begin
          state_d = READ;
          idx_d   = mem_address[IDX_W-1:0];
          cnt_d   = CNT_W'(READ_LATENCY - 1);
        end
      end
      READ: begin
        busy = 1'b1;
        if (!mem_read) begin
          // Requester gave up: drop the read, keep the last returned block.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // Array read is combinational, so a write on this same edge is
          // not seen here; earlier writes are.
          state_d    = RESPOND;
          readinst_d = rd_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate with reset so busywait is low during reset even with mem_read high.
  assign mem_busywait = busy & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      mem_readinst <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mem_readinst <= readinst_d;
    end
  end

  // Address bits above the block index alias onto the same storage.
  logic unused_prog_lo;
  assign unused_prog_lo = ^prog.addr[1:0];

  if (IDX_W < BLOCK_ADDR_WIDTH) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{mem_address[BLOCK_ADDR_WIDTH-1:IDX_W], prog.addr[31:IDX_W+4]};
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
module tb_instruction_memory_responder;

  localparam int RL = 5;
  localparam logic [127:0] B1 = 128'h00300193_00200113_00100093_00000013;
  localparam logic [127:0] B0 = 128'hA0000003_A0000002_A0000001_A0000000;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         mem_read = 1'b0;
  logic [27:0]  mem_address = '0;
  logic [127:0] mem_readinst;
  logic         mem_busywait;
  logic         prog_en = 1'b0;
  logic [31:0]  prog_addr = '0;
  logic [31:0]  prog_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  instruction_memory_responder #(.READ_LATENCY(RL), .BLOCK_INDEX_BITS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait),
    .prog_en      (prog_en),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a request is outstanding for RL edges after the edge
  // that accepted it, then returns the block as it stood before that edge's
  // write; one non-busy response cycle follows before a new request is taken.
  logic [31:0]  m_mem [256][4];
  bit           m_inflight = 0;
  bit           m_respond  = 0;
  int           m_left     = 0;
  int           m_idx      = 0;
  logic [127:0] m_inst     = '0;

  function automatic logic [127:0] m_block(input int i);
    return {m_mem[i][3], m_mem[i][2], m_mem[i][1], m_mem[i][0]};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_inflight = 0;
      m_respond  = 0;
      m_left     = 0;
      m_inst     = '0;
    end else begin
      if (m_inflight) begin
        if (!mem_read) m_inflight = 0;
        else if (m_left == 1) begin
          m_inst     = m_block(m_idx);
          m_inflight = 0;
          m_respond  = 1;
        end else m_left--;
      end else if (m_respond) m_respond = 0;
      else if (mem_read) begin
        m_inflight = 1;
        m_left     = RL;
        m_idx      = int'(mem_address % 256);
      end
      if (prog_en) m_mem[prog_addr[11:4]][prog_addr[3:2]] = prog_data;
    end
  end

  always @(negedge clock) begin
    check("busywait", {127'b0, mem_busywait},
          {127'b0, (!reset) ? 1'b0 : m_inflight ? 1'b1 : m_respond ? 1'b0 : mem_read});
    check("readinst", mem_readinst, m_inst);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_en   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_en   = 1'b0;
  endtask

  // Counts edges after capture until busywait drops, scrambling the address.
  task automatic finish_read(input int already, output int n);
    n = already;
    do begin
      mem_address = 28'($urandom);
      step();
      n++;
    end while (mem_busywait && n < 300);
    if (n >= 300) check("read_timeout", 1, 0);
  endtask

  task automatic read_block(input logic [27:0] a, output int n);
    mem_address = a;
    mem_read    = 1'b1;
    #1 check("busy_same_cycle", {127'b0, mem_busywait}, 128'd1);
    step();
    finish_read(0, n);
    mem_read = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem_read = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_busy", {127'b0, mem_busywait}, 128'd0);
    check("reset_inst", mem_readinst, 128'd0);
    step(); step();
    mem_read = 1'b0;
    reset = 1'b1;
    step();

    // Fill every block; upper and low address bits are noise.
    for (int b = 0; b < 256; b++)
      for (int w = 0; w < 4; w++)
        prog({20'($urandom), 8'(b), 2'(w), 2'($urandom)}, $urandom);
    for (int w = 0; w < 4; w++) begin
      prog(32'(w * 4), 32'hA0000000 + 32'(w));
      prog(32'h10 + 32'(w * 4), 32'(w) * 32'h00100080 + 32'h13 + (w > 0 ? 32'h0 : 32'h0));
    end
    // Block 1 words must be exactly 0x13, 0x100093, 0x200113, 0x300193.
    prog(32'h14, 32'h00100093);
    prog(32'h18, 32'h00200113);
    prog(32'h1C, 32'h00300193);

    read_block(28'h0000001, n);
    check("lat_first", n, RL);
    check("data_first", mem_readinst, B1);

    read_block(28'h0000000, n);
    check("lat_b2b_a", n, RL);
    check("data_b2b_a", mem_readinst, B0);
    check("hold_b2b", mem_readinst, B0);
    read_block(28'h0000001, n);
    check("lat_b2b_b", n, RL);
    check("data_b2b_b", mem_readinst, B1);

    read_block(28'h0000100, n);
    check("alias_100", mem_readinst, B0);
    read_block(28'hFFFFF01, n);
    check("alias_fff01", mem_readinst, B1);

    // Abort after two edges in READ.
    read_block(28'h0000000, n);
    mem_address = 28'h0000001;
    mem_read = 1'b1;
    step(); step(); step();
    mem_read = 1'b0;
    step();
    check("abort_busy", {127'b0, mem_busywait}, 128'd0);
    check("abort_inst", mem_readinst, B0);
    read_block(28'h0000001, n);
    check("after_abort", mem_readinst, B1);

    // Reset in the middle of a read, request still held.
    mem_address = 28'h0000000;
    mem_read = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {127'b0, mem_busywait}, 128'd0);
    check("rst_mid_inst", mem_readinst, 128'd0);
    step(); step();
    reset = 1'b1;
    step();
    finish_read(0, n);
    mem_read = 1'b0;
    check("rst_reread_lat", n, RL);
    check("rst_reread_data", mem_readinst, B0);
    step();

    // Preload into the in-flight block during READ.
    mem_address = 28'h0000001;
    mem_read = 1'b1;
    step(); step(); step();
    prog(32'h18, 32'hDEADBEEF);
    finish_read(3, n);
    mem_read = 1'b0;
    check("inflight_lat", n, RL);
    check("inflight_data", mem_readinst, 128'h00300193_DEADBEEF_00100093_00000013);
    step();

    // Write on the completing edge returns the pre-write data.
    mem_address = 28'h0000000;
    mem_read = 1'b1;
    step();
    repeat (RL - 1) step();
    prog(32'h0, 32'h55555555);
    mem_read = 1'b0;
    check("complete_edge_busy", {127'b0, mem_busywait}, 128'd0);
    check("complete_edge_old", mem_readinst, B0);
    step();
    read_block(28'h0000000, n);
    check("complete_edge_new", mem_readinst, 128'hA0000003_A0000002_A0000001_55555555);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (!reset) begin
        if ($urandom_range(2) == 0) reset = 1'b1;
        prog_en = 1'b0;
      end else if ($urandom_range(149) == 0) begin
        reset = 1'b0;
        prog_en = 1'b0;
      end else begin
        prog_en   = ($urandom_range(3) == 0);
        prog_addr = $urandom;
        prog_data = $urandom;
      end
      if (mem_read) mem_read = ($urandom_range(15) != 0);
      else mem_read = ($urandom_range(2) == 0);
      mem_address = ($urandom_range(1) == 0) ? 28'($urandom_range(3)) : 28'($urandom);
      step();
    end
    prog_en  = 1'b0;
    mem_read = 1'b0;
    reset    = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
